// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM encoding and LFSR helpers for the random-word arbiter
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Register width for a counter/pointer that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Fibonacci step on an n-bit state carried in a 32-bit container.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ((state << 1) | {31'd0, ^(state & taps)}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// rtl/lfsr_rng_arbiter_if.sv - request/grant/word bundle between requesters and the arbiter
interface lfsr_rng_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [N-1:0]    data;
  logic            data_valid;

  modport master (output req, input gnt, input data, input data_valid);
  modport slave  (input req, output gnt, output data, output data_valid);

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority one-hot select; req[ptr] has highest priority
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[PW'(j)]) begin
        gnt          = '0;
        gnt[PW'(j)]  = 1'b1;
        idx          = PW'(j);
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// rtl/lfsr_rng_arbiter.sv - round-robin shared LFSR producing one N-bit word per grant
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int           N    = 4,
  parameter logic [N-1:0] TAPS = 4'b1001,
  parameter int           NREQ = 4,
  parameter logic [N-1:0] SEED = 4'b0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seed_load,
  input  logic [N-1:0]        seed_val,
  lfsr_rng_arbiter_if.slave   bus,
  output logic                busy,
  output logic                seed_err
);

  localparam int CW = cnt_width(N);
  localparam int PW = cnt_width(NREQ);

  fsm_t            fsm;
  logic [N-1:0]    state;
  logic [N-1:0]    state_step;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // An all-zero state would never leave zero, so it is replaced by SEED.
  assign state_step = (state == '0) ? SEED
                                    : N'(lfsr_next(32'(state), 32'(TAPS), N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm            <= IDLE;
      state          <= SEED;
      cnt            <= '0;
      ptr            <= '0;
      gidx           <= '0;
      bus.gnt        <= '0;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      busy           <= 1'b0;
      seed_err       <= 1'b0;
    end else begin
      seed_err <= 1'b0;
      case (fsm)
        IDLE: begin
          if (seed_load) begin
            if (seed_val == '0) begin
              state    <= SEED;
              seed_err <= 1'b1;
            end else begin
              state <= seed_val;
            end
          end else if (|bus.req) begin
            bus.gnt <= pick_gnt;
            gidx    <= pick_idx;
            cnt     <= CW'(N - 1);
            busy    <= 1'b1;
            fsm     <= SHIFT;
          end
        end
        SHIFT: begin
          state <= state_step;
          if (seed_load) seed_err <= 1'b1;
          if (cnt == '0) begin
            bus.data       <= state_step;
            bus.data_valid <= 1'b1;
            fsm            <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (seed_load) seed_err <= 1'b1;
          bus.data_valid <= 1'b0;
          bus.gnt        <= '0;
          busy           <= 1'b0;
          ptr            <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          fsm            <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb/tb_lfsr_rng_arbiter.sv - directed self-checking bench for lfsr_rng_arbiter
module tb_lfsr_rng_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed_val = 4'h0;
  logic       busy;
  logic       seed_err;

  int checks = 0;
  int errors = 0;

  lfsr_rng_arbiter_if #(.N(4), .NREQ(4)) bus ();

  lfsr_rng_arbiter #(.N(4), .TAPS(4'b1001), .NREQ(4), .SEED(4'b0001)) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .bus       (bus),
    .busy      (busy),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bus.req   = 4'b0000;
    seed_load = 1'b0;
    seed_val  = 4'h0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_dv(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 20) begin
      tick();
      cyc++;
      if (bus.data_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_dv: data_valid not seen within 20 cycles");
    end
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", bus.data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL reset_seed_err: got %b want 0", seed_err); end
    checks++; if (bus.data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data); end
    checks++; if (dut.state !== 4'b0001) begin errors++; $display("FAIL reset_state: got %b want 0001", dut.state); end
    bus.req = 4'b0001;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000 || busy !== 1'b0 || bus.data_valid !== 1'b0) begin
      errors++; $display("FAIL midshift_async_clear: gnt %b busy %b dv %b want 0000 0 0", bus.gnt, busy, bus.data_valid);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.data_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midshift_no_dv: data_valid pulsed after abort, want none"); end
    checks++; if (dut.state !== 4'b0001) begin errors++; $display("FAIL midshift_state: got %b want 0001", dut.state); end
  endtask

  task automatic test_single_word();
    bit ok;
    bit early;
    int cyc;
    do_reset();
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant: gnt %b busy %b want 0001 1", bus.gnt, busy);
    end
    bus.req = 4'b0000;
    early = 1'b0;
    repeat (3) begin
      tick();
      if (bus.data_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL single_early_dv: data_valid before E0+N, want low"); end
    tick();
    checks++; if (bus.data_valid !== 1'b1 || bus.data !== 4'b1110 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL single_word1: dv %b data %b gnt %b want 1 1110 0001", bus.data_valid, bus.data, bus.gnt);
    end
    tick();
    checks++; if (bus.data_valid !== 1'b0 || bus.gnt !== 4'b0000 || busy !== 1'b0 || bus.data !== 4'b1110) begin
      errors++; $display("FAIL single_after: dv %b gnt %b busy %b data %b want 0 0000 0 1110",
                         bus.data_valid, bus.gnt, busy, bus.data);
    end
    bus.req = 4'b0001;
    wait_dv(ok, cyc);
    bus.req = 4'b0000;
    checks++; if (bus.data !== 4'b1011 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL single_word2: data %b gnt %b want 1011 0001", bus.data, bus.gnt);
    end
    tick();
  endtask

  task automatic test_period();
    logic [3:0] exp_w [16];
    bit ok;
    int cyc;
    int bad;
    exp_w = '{4'hE, 4'hB, 4'h2, 4'h3, 4'hD, 4'h6, 4'h4, 4'h7,
              4'hA, 4'hC, 4'h8, 4'hF, 4'h5, 4'h9, 4'h1, 4'hE};
    do_reset();
    bus.req = 4'b0001;
    bad = 0;
    for (int w = 0; w < 16; w++) begin
      wait_dv(ok, cyc);
      checks++;
      if (bus.data !== exp_w[w]) begin
        errors++; bad++;
        $display("FAIL period_word%0d: got %h want %h", w, bus.data, exp_w[w]);
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [5];
    logic [3:0] exp_b [4];
    bit ok;
    bit oh_bad;
    int cyc;
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      ok = 1'b0; cyc = 0; oh_bad = 1'b0;
      while (!ok && cyc < 20) begin
        tick();
        cyc++;
        if (!$onehot0(bus.gnt)) oh_bad = 1'b1;
        if (bus.data_valid === 1'b1) ok = 1'b1;
      end
      checks++; if (!ok || bus.gnt !== exp_a[g]) begin
        errors++; $display("FAIL rr_all_%0d: dv %b gnt %b want 1 %b", g, ok, bus.gnt, exp_a[g]);
      end
      checks++; if (oh_bad) begin errors++; $display("FAIL rr_all_onehot_%0d: multi-hot grant seen, want one-hot", g); end
      if (g > 0) begin
        checks++; if (cyc != 6) begin errors++; $display("FAIL back_to_back_%0d: spacing %0d want 6", g, cyc); end
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
    do_reset();
    bus.req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0; cyc = 0; oh_bad = 1'b0;
      while (!ok && cyc < 20) begin
        tick();
        cyc++;
        if (!$onehot0(bus.gnt)) oh_bad = 1'b1;
        if (bus.data_valid === 1'b1) ok = 1'b1;
      end
      checks++; if (!ok || bus.gnt !== exp_b[g] || oh_bad) begin
        errors++; $display("FAIL rr_1010_%0d: dv %b gnt %b multihot %b want 1 %b 0", g, ok, bus.gnt, oh_bad, exp_b[g]);
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_seeding();
    bit ok;
    int cyc;
    do_reset();
    seed_val = 4'b1000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (seed_err !== 1'b0 || dut.state !== 4'b1000) begin
      errors++; $display("FAIL seed_load_ok: seed_err %b state %b want 0 1000", seed_err, dut.state);
    end
    seed_val = 4'b0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (seed_err !== 1'b1 || dut.state !== 4'b0001 || busy !== 1'b0) begin
      errors++; $display("FAIL seed_zero: seed_err %b state %b busy %b want 1 0001 0", seed_err, dut.state, busy);
    end
    tick();
    checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL seed_zero_pulse: seed_err %b want 0", seed_err); end
    bus.req = 4'b0001;
    wait_dv(ok, cyc);
    bus.req = 4'b0000;
    checks++; if (bus.data !== 4'b1110) begin errors++; $display("FAIL seed_zero_word: got %b want 1110", bus.data); end
    tick();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    seed_val = 4'b0101; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (seed_err !== 1'b1) begin errors++; $display("FAIL seed_busy_err: got %b want 1", seed_err); end
    tick();
    checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL seed_busy_pulse: got %b want 0", seed_err); end
    wait_dv(ok, cyc);
    checks++; if (bus.data !== 4'b1011) begin errors++; $display("FAIL seed_busy_word: got %b want 1011", bus.data); end
    tick();
    seed_val = 4'b1000; seed_load = 1'b1; bus.req = 4'b0001;
    tick();
    seed_load = 1'b0;
    checks++; if (bus.gnt !== 4'b0000 || busy !== 1'b0 || seed_err !== 1'b0 || dut.state !== 4'b1000) begin
      errors++; $display("FAIL seed_vs_req_first: gnt %b busy %b err %b state %b want 0000 0 0 1000",
                         bus.gnt, busy, seed_err, dut.state);
    end
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL seed_vs_req_grant: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    wait_dv(ok, cyc);
    checks++; if (bus.data !== 4'b1111) begin errors++; $display("FAIL seed_vs_req_word: got %b want 1111", bus.data); end
    tick();
  endtask

  task automatic test_drop_req();
    bit ok;
    int cyc;
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt_held: got %b want 0001", bus.gnt); end
    wait_dv(ok, cyc);
    checks++; if (bus.gnt !== 4'b0001 || bus.data !== 4'b1110) begin
      errors++; $display("FAIL drop_word: gnt %b data %b want 0001 1110", bus.gnt, bus.data);
    end
    tick();
    bus.req = 4'b0011;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL drop_next_port: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    wait_dv(ok, cyc);
    checks++; if (bus.data !== 4'b1011) begin errors++; $display("FAIL drop_next_word: got %b want 1011", bus.data); end
    tick();
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_single_word();
    test_period();
    test_round_robin();
    test_seeding();
    test_drop_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
